// File: rtl/sha256_compress.sv
`timescale 1ns/1ps
// sha256_compress
// Runs the SHA-256 compression function on one padded 512-bit block per
// accepted handshake, one round per clock, and chains H0..H7 across the
// blocks of a message. The digest is published only after the last block.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   Data        message block, word i = Data[i*Nw +: Nw], word 0 is W[0]
//   Valid       block present (accepted only while idle)
//   First       with Valid: block starts a new message, chain from the IV
//   Last        with Valid: block ends the message, publish the digest
//   Busy        block accepted and in progress (65 cycles per block)
//   Hash        digest, H0 in [255:224] down to H7 in [31:0]
//   Hash_Valid  one-cycle pulse when Hash is updated
module sha256_compress #(
    parameter int Nw = 32,
    parameter int Nb = 512,
    parameter int Nh = 256,
    parameter int Nr = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [Nb-1:0] Data,
    input  logic          Valid,
    input  logic          First,
    input  logic          Last,
    output logic          Busy,
    output logic [Nh-1:0] Hash,
    output logic          Hash_Valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUND  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [255:0] IV_C = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [5:0]   LAST_ROUND_C = 6'(Nr - 1);

    // Round constant table, indexed by round number.
    function automatic logic [31:0] k_const(input logic [5:0] idx);
        logic [31:0] k;
        case (idx)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
            default: k = 32'h00000000;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    function automatic logic [31:0] ch_fn(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj_fn(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    state_t      state_r;
    logic [5:0]  t_r;
    logic [31:0] a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r;
    logic [31:0] hs_r [8];
    logic [31:0] w_r [16];
    logic        last_r;
    logic        busy_r;
    logic [255:0] hash_r;
    logic        hash_valid_r;

    logic [31:0] t1_s;
    logic [31:0] t2_s;
    logic [31:0] w_new_s;
    logic [31:0] sum_s [8];
    logic [255:0] digest_s;

    // Round datapath: the window always presents W[t] in word 0, and the
    // word appended at the top is W[t+16] built from W[t+14], W[t+9], W[t+1], W[t].
    always_comb begin
        t1_s    = h_r + big_sigma1(e_r) + ch_fn(e_r, f_r, g_r) + k_const(t_r) + w_r[0];
        t2_s    = big_sigma0(a_r) + maj_fn(a_r, b_r, c_r);
        w_new_s = small_sigma1(w_r[14]) + w_r[9] + small_sigma0(w_r[1]) + w_r[0];
    end

    // Chaining sums for the end-of-block update and the published digest.
    always_comb begin
        sum_s[0] = hs_r[0] + a_r;
        sum_s[1] = hs_r[1] + b_r;
        sum_s[2] = hs_r[2] + c_r;
        sum_s[3] = hs_r[3] + d_r;
        sum_s[4] = hs_r[4] + e_r;
        sum_s[5] = hs_r[5] + f_r;
        sum_s[6] = hs_r[6] + g_r;
        sum_s[7] = hs_r[7] + h_r;
        digest_s = {sum_s[0], sum_s[1], sum_s[2], sum_s[3], sum_s[4], sum_s[5], sum_s[6], sum_s[7]};
    end

    // Control FSM together with working variables, schedule window and chaining state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            t_r          <= 6'd0;
            a_r          <= 32'h0; b_r <= 32'h0; c_r <= 32'h0; d_r <= 32'h0;
            e_r          <= 32'h0; f_r <= 32'h0; g_r <= 32'h0; h_r <= 32'h0;
            for (int i = 0; i < 8; i++) hs_r[i] <= IV_C[(7 - i) * 32 +: 32];
            for (int i = 0; i < 16; i++) w_r[i] <= 32'h0;
            last_r       <= 1'b0;
            busy_r       <= 1'b0;
            hash_r       <= 256'h0;
            hash_valid_r <= 1'b0;
        end else begin
            hash_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (Valid) begin
                        for (int i = 0; i < 16; i++) w_r[i] <= Data[i * Nw +: Nw];
                        last_r <= Last;
                        if (First) begin
                            for (int i = 0; i < 8; i++) hs_r[i] <= IV_C[(7 - i) * 32 +: 32];
                            a_r <= IV_C[255:224]; b_r <= IV_C[223:192];
                            c_r <= IV_C[191:160]; d_r <= IV_C[159:128];
                            e_r <= IV_C[127:96];  f_r <= IV_C[95:64];
                            g_r <= IV_C[63:32];   h_r <= IV_C[31:0];
                        end else begin
                            a_r <= hs_r[0]; b_r <= hs_r[1]; c_r <= hs_r[2]; d_r <= hs_r[3];
                            e_r <= hs_r[4]; f_r <= hs_r[5]; g_r <= hs_r[6]; h_r <= hs_r[7];
                        end
                        t_r     <= 6'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_ROUND;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    h_r <= g_r;
                    g_r <= f_r;
                    f_r <= e_r;
                    e_r <= d_r + t1_s;
                    d_r <= c_r;
                    c_r <= b_r;
                    b_r <= a_r;
                    a_r <= t1_s + t2_s;
                    for (int i = 0; i < 15; i++) w_r[i] <= w_r[i + 1];
                    w_r[15] <= w_new_s;
                    t_r     <= t_r + 6'd1;
                    if (t_r == LAST_ROUND_C) begin
                        state_r <= ST_UPDATE;
                    end else begin
                        state_r <= ST_ROUND;
                    end
                end
                ST_UPDATE: begin
                    for (int i = 0; i < 8; i++) hs_r[i] <= sum_s[i];
                    // Intermediate blocks only advance the chain; Hash is
                    // touched solely at the end of a message.
                    if (last_r) begin
                        hash_r       <= digest_s;
                        hash_valid_r <= 1'b1;
                    end else begin
                        hash_r       <= hash_r;
                    end
                    t_r     <= 6'd0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    t_r     <= 6'd0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy       = busy_r;
    assign Hash       = hash_r;
    assign Hash_Valid = hash_valid_r;

endmodule

// File: tb/tb_sha256_compress.sv
`timescale 1ns/1ps
module tb_sha256_compress;

    logic         clk;
    logic         rst;
    logic [511:0] Data;
    logic         Valid;
    logic         First;
    logic         Last;
    logic         Busy;
    logic [255:0] Hash;
    logic         Hash_Valid;

    sha256_compress dut (
        .clk        (clk),
        .rst        (rst),
        .Data       (Data),
        .Valid      (Valid),
        .First      (First),
        .Last       (Last),
        .Busy       (Busy),
        .Hash       (Hash),
        .Hash_Valid (Hash_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Reference model state: chaining value and the last published digest.
    logic [255:0] h_model;
    logic [255:0] hash_model;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Whole-block compression computed the textbook way: full 64-word schedule, then 64 rounds.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[t*32 +: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    // Standard SHA-256 padding for messages of up to 119 bytes (one or two blocks).
    function automatic void pad_msg(input string s, output logic [511:0] b0, output logic [511:0] b1, output int nblk);
        logic [7:0] bytes [128];
        int len;
        logic [63:0] bits;
        len = s.len();
        for (int i = 0; i < 128; i++) bytes[i] = 8'h00;
        for (int i = 0; i < len; i++) bytes[i] = s[i];
        bytes[len] = 8'h80;
        nblk = (len + 9 > 64) ? 2 : 1;
        bits = 64'(len) * 64'd8;
        for (int k = 0; k < 8; k++) bytes[nblk*64 - 1 - k] = bits[8*k +: 8];
        for (int i = 0; i < 16; i++) begin
            b0[i*32 +: 32] = {bytes[4*i], bytes[4*i+1], bytes[4*i+2], bytes[4*i+3]};
            b1[i*32 +: 32] = {bytes[64+4*i], bytes[64+4*i+1], bytes[64+4*i+2], bytes[64+4*i+3]};
        end
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    // Present one block, follow it to completion and check timing, pulse and digest.
    task automatic run_block(input logic [511:0] blk, input bit first, input bit last, input bit garbage);
        int waitn;
        int busy_len;
        int pulses;
        int pulse_edge;
        waitn = 0;
        while (Busy && waitn < 200) begin
            @(posedge clk); #1;
            waitn++;
        end
        chk("idle_before_accept", {255'd0, Busy}, 256'd0);
        Data = blk; First = first; Last = last; Valid = 1'b1;
        @(posedge clk); #1;
        Valid = 1'b0; First = 1'b0; Last = 1'b0; Data = rand_block();
        chk("busy_after_accept", {255'd0, Busy}, 256'd1);
        chk("no_pulse_at_accept", {255'd0, Hash_Valid}, 256'd0);
        if (first) h_model = IV;
        h_model = ref_compress(h_model, blk);
        if (last) hash_model = h_model;
        busy_len = 0; pulses = 0; pulse_edge = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (Hash_Valid) begin
                pulses++;
                pulse_edge = n;
            end
            if (!Busy) begin
                busy_len = n;
                break;
            end
            if (garbage && (n == 10 || n == 40)) begin
                Data = rand_block(); First = 1'b1; Last = 1'b1; Valid = 1'b1;
            end else begin
                Valid = 1'b0; First = 1'b0; Last = 1'b0;
            end
        end
        Valid = 1'b0; First = 1'b0; Last = 1'b0;
        chk("busy_cycles", 256'(busy_len), 256'd65);
        chk("pulse_count", 256'(pulses), last ? 256'd1 : 256'd0);
        if (last) chk("pulse_edge", 256'(pulse_edge), 256'd65);
        chk("hash_value", Hash, hash_model);
    endtask

    typedef struct {
        string        msg;
        logic [255:0] digest;
    } kat_t;

    kat_t kat [3];

    initial begin
        logic [511:0] b0, b1;
        int nblk;
        int cnt;

        kat[0].msg = "abc";
        kat[0].digest = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        kat[1].msg = "";
        kat[1].digest = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
        kat[2].msg = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        kat[2].digest = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

        h_model = IV;
        hash_model = 256'd0;
        rst = 1'b0; Valid = 1'b0; First = 1'b0; Last = 1'b0; Data = 512'd0;
        #12;
        chk("reset_busy", {255'd0, Busy}, 256'd0);
        chk("reset_hash_valid", {255'd0, Hash_Valid}, 256'd0);
        chk("reset_hash", Hash, 256'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Known-answer table: each message padded, blocks tagged First/Last.
        for (int k = 0; k < 3; k++) begin
            pad_msg(kat[k].msg, b0, b1, nblk);
            run_block(b0, 1'b1, nblk == 1, 1'b0);
            if (nblk == 2) run_block(b1, 1'b0, 1'b1, 1'b0);
            chk($sformatf("kat_%0d_digest", k), Hash, kat[k].digest);
        end

        // Garbage Valid pulses during Busy must be ignored.
        pad_msg("abc", b0, b1, nblk);
        run_block(b0, 1'b1, 1'b1, 1'b1);
        chk("garbage_abc_digest", Hash, kat[0].digest);

        // Randomised blocks with random message boundaries against the model.
        for (int r = 0; r < 12; r++) begin
            run_block(rand_block(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset during round 30 of "abc", then resend with First=0 (chain must restart from IV).
        Data = b0; First = 1'b1; Last = 1'b1; Valid = 1'b1;
        @(posedge clk); #1;
        Valid = 1'b0; First = 1'b0; Last = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midround_reset_busy", {255'd0, Busy}, 256'd0);
        chk("midround_reset_hash", Hash, 256'd0);
        cnt = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (Hash_Valid) cnt++;
        end
        @(negedge clk); rst = 1'b1;
        h_model = IV;
        hash_model = 256'd0;
        repeat (70) begin
            @(posedge clk); #1;
            if (Hash_Valid) cnt++;
        end
        chk("midround_no_pulse", 256'(cnt), 256'd0);
        chk("midround_hash_held", Hash, 256'd0);
        run_block(b0, 1'b0, 1'b1, 1'b0);
        chk("resend_abc_digest", Hash, kat[0].digest);

        // Back-to-back: "abc" then empty message accepted on the very next edge.
        run_block(b0, 1'b1, 1'b1, 1'b0);
        chk("b2b_abc_digest", Hash, kat[0].digest);
        pad_msg("", b0, b1, nblk);
        run_block(b0, 1'b1, 1'b1, 1'b0);
        chk("b2b_empty_digest", Hash, kat[1].digest);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
